riscv_bus_ctrl: RTL and testbench
=================================

RISCV_BUS_CTRL -- requirements
Module: riscv_bus_ctrl

Interface
REQ-001 The module SHALL have parameter XLEN, default riscv_pkg::XLEN (32), address/data width.
REQ-002 The module SHALL have parameter BUS_SLAVES, default riscv_pkg::BUS_SLAVES (3), number of slave ports.
REQ-003 The module SHALL have parameter TIMEOUT_CYC, default riscv_pkg::BUS_TIMEOUT (255), the WAIT-state cycle limit.
REQ-004 The module SHALL have port clk_i, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The module SHALL have port arstn_i, input, 1, the reset: asynchronous, active-low.
REQ-006 The module SHALL have master request ports: m_req_i (in, 1); m_we_i (in, 1); m_addr_i (in, XLEN); m_wdata_i (in, XLEN); m_be_i (in, XLEN/8).
REQ-007 The module SHALL have master response ports: m_gnt_o (out, 1, request accepted); m_rvalid_o (out, 1, response pulse); m_rdata_o (out, XLEN); m_err_o (out, 1, qualified by m_rvalid_o).
REQ-008 The module SHALL have slave request ports: s_req_o (out, BUS_SLAVES, one-hot); s_we_o (out, 1); s_addr_o (out, XLEN); s_wdata_o (out, XLEN); s_be_o (out, XLEN/8).
REQ-009 The module SHALL have slave response ports: s_rvalid_i (in, BUS_SLAVES); s_rdata_i (in, BUS_SLAVES*XLEN), with slave i data in bits [i*XLEN +: XLEN].

Function
REQ-010 Decode SHALL be idx = m_addr_i[XLEN-1:XLEN-4]: idx < BUS_SLAVES selects slave idx; any other value is a decode error.
REQ-011 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT, RESP and ERR.
REQ-012 In IDLE, m_gnt_o SHALL equal m_req_i (combinational); m_gnt_o SHALL be 0 in every other state.
REQ-013 On grant, the controller SHALL register we, addr, wdata, be and idx, then go to ISSUE (valid idx) or ERR (decode error).
REQ-014 ISSUE SHALL last one cycle: s_req_o[idx]=1 with all other bits 0, then go to WAIT.
REQ-015 s_we_o, s_addr_o, s_wdata_o and s_be_o SHALL hold the registered values from ISSUE until the FSM returns to IDLE.
REQ-016 In WAIT, s_rvalid_i[idx]=1 SHALL capture s_rdata_i slice idx and move to RESP; s_rvalid_i bits of non-selected slaves SHALL be ignored.
REQ-017 s_rvalid_i[idx] asserted in the ISSUE cycle SHALL be accepted the same way as in WAIT.
REQ-018 The WAIT counter SHALL clear on entry, increment each WAIT cycle, and on reaching TIMEOUT_CYC without a response move to ERR.
REQ-019 A slave response arriving in the same cycle as the timeout SHALL take priority, so the FSM goes to RESP.
REQ-020 RESP SHALL last one cycle: m_rvalid_o=1, m_err_o=0, m_rdata_o=captured data (writes also produce this acknowledge); then go to IDLE.
REQ-021 ERR SHALL last one cycle: m_rvalid_o=1, m_err_o=1, m_rdata_o=0; then go to IDLE.
REQ-022 Latency SHALL be: grant at cycle T, s_req_o at T+1, m_rvalid_o one cycle after the accepted s_rvalid_i; a decode error gives m_rvalid_o at T+1.
REQ-023 Back-to-back requests SHALL be granted no earlier than the cycle after RESP/ERR (one outstanding transaction).
REQ-024 Any s_rvalid_i activity in IDLE, RESP or ERR SHALL be ignored.

Reset
REQ-025 While arstn_i=0, the FSM SHALL be in IDLE and the counter at 0.
REQ-026 While arstn_i=0, outputs SHALL be: m_rvalid_o=0, m_err_o=0, m_rdata_o=0, s_req_o=0, s_we_o=0, s_addr_o=0, s_wdata_o=0, s_be_o=0.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction with no response pulse after release.

Structure
REQ-028 riscv_pkg SHALL gain BUS_TIMEOUT (255), the enum bus_state_t, and slave indices SLV_RAM=0, SLV_GPIO=1, SLV_UART=2.
REQ-029 Address decode SHALL be one sub-module, riscv_bus_decoder, which outputs idx and a decode-error flag.

Verification
REQ-030 Read to 0x0000_0010, RAM responds 2 cycles after s_req with 0xDEADBEEF -> s_req_o=001, then m_rvalid_o pulse with m_rdata_o=0xDEADBEEF, m_err_o=0.
REQ-031 Write 0x0000_00A5 to 0x1000_0000, be=0001 -> s_req_o=010, s_we_o=1, s_wdata_o=0xA5, s_be_o=0001, then ack with m_err_o=0.
REQ-032 Access to 0x3000_0000 -> s_req_o stays 000; m_rvalid_o=1, m_err_o=1, m_rdata_o=0 at T+1.
REQ-033 UART never responds -> m_err_o pulse exactly TIMEOUT_CYC WAIT cycles after ISSUE; a response arriving in the timeout cycle -> normal RESP.
REQ-034 GPIO and UART assert rvalid together during a UART access -> only UART data is returned; m_req_i held continuously -> grants separated by at least one cycle after each response.
REQ-035 arstn_i pulsed low in WAIT -> all outputs 0, FSM in IDLE, no m_rvalid_o after release; the next request completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared bus-controller constants: widths, timeout, slave map and FSM state encoding.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int BUS_SLAVES  = 3;
    localparam int BUS_TIMEOUT = 255;

    localparam int SLV_RAM  = 0;
    localparam int SLV_GPIO = 1;
    localparam int SLV_UART = 2;

    typedef enum logic [2:0] {
        BUS_IDLE  = 3'd0,
        BUS_ISSUE = 3'd1,
        BUS_WAIT  = 3'd2,
        BUS_RESP  = 3'd3,
        BUS_ERR   = 3'd4
    } bus_state_t;

endpackage

// File: rtl/riscv_bus_decoder.sv
// Address decode: the top address nibble selects the slave; nibbles past the
// last populated slave are reported as a decode error.
module riscv_bus_decoder #(
    parameter int BUS_SLAVES = riscv_pkg::BUS_SLAVES
) (
    input  logic [3:0] i_sel,
    output logic [3:0] o_idx,
    output logic       o_err
);

    assign o_idx = i_sel;
    assign o_err = (int'(i_sel) >= BUS_SLAVES);

endmodule

// File: rtl/riscv_bus_ctrl.sv
// Single-outstanding bus controller: one master, BUS_SLAVES slaves, with
// address decode, a bounded wait for the slave response and an error reply.
//
// state | meaning
// IDLE  | ready; master request is granted combinationally
// ISSUE | one-cycle s_req pulse to the selected slave
// WAIT  | waiting for the selected slave's rvalid, bounded by TIMEOUT_CYC
// RESP  | one-cycle good response to the master
// ERR   | one-cycle error response (decode error or timeout)
module riscv_bus_ctrl #(
    parameter int XLEN        = riscv_pkg::XLEN,
    parameter int BUS_SLAVES  = riscv_pkg::BUS_SLAVES,
    parameter int TIMEOUT_CYC = riscv_pkg::BUS_TIMEOUT
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    input  logic                       m_req_i,
    input  logic                       m_we_i,
    input  logic [XLEN-1:0]            m_addr_i,
    input  logic [XLEN-1:0]            m_wdata_i,
    input  logic [XLEN/8-1:0]          m_be_i,
    output logic                       m_gnt_o,
    output logic                       m_rvalid_o,
    output logic [XLEN-1:0]            m_rdata_o,
    output logic                       m_err_o,
    output logic [BUS_SLAVES-1:0]      s_req_o,
    output logic                       s_we_o,
    output logic [XLEN-1:0]            s_addr_o,
    output logic [XLEN-1:0]            s_wdata_o,
    output logic [XLEN/8-1:0]          s_be_o,
    input  logic [BUS_SLAVES-1:0]      s_rvalid_i,
    input  logic [BUS_SLAVES*XLEN-1:0] s_rdata_i
);
    import riscv_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    bus_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_wdata;
    logic [XLEN/8-1:0]  r_be;
    logic [3:0]         r_idx;
    logic [XLEN-1:0]    r_rdata;

    logic [3:0]             w_idx;
    logic                   w_dec_err;
    logic                   w_sel_rvalid;
    logic [XLEN-1:0]        w_sel_rdata;
    logic [BUS_SLAVES-1:0]  w_sreq;
    logic                   w_timeout;

    riscv_bus_decoder #(
        .BUS_SLAVES (BUS_SLAVES)
    ) u_decoder (
        .i_sel (m_addr_i[XLEN-1 -: 4]),
        .o_idx (w_idx),
        .o_err (w_dec_err)
    );

    // Only the latched slave's rvalid/rdata are looked at; the others are don't-care.
    always_comb begin
        w_sel_rvalid = 1'b0;
        w_sel_rdata  = '0;
        w_sreq       = '0;
        for (int i = 0; i < BUS_SLAVES; i++) begin
            if (r_idx == 4'(i)) begin
                w_sel_rvalid = s_rvalid_i[i];
                w_sel_rdata  = s_rdata_i[i*XLEN +: XLEN];
                w_sreq[i]    = (r_state == BUS_ISSUE);
            end
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= BUS_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_idx   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                BUS_IDLE: begin
                    if (m_req_i) begin
                        r_we    <= m_we_i;
                        r_addr  <= m_addr_i;
                        r_wdata <= m_wdata_i;
                        r_be    <= m_be_i;
                        r_idx   <= w_idx;
                        r_state <= w_dec_err ? BUS_ERR : BUS_ISSUE;
                    end
                end
                BUS_ISSUE: begin
                    r_cnt <= '0;
                    if (w_sel_rvalid) begin
                        r_rdata <= w_sel_rdata;
                        r_state <= BUS_RESP;
                    end else begin
                        r_state <= BUS_WAIT;
                    end
                end
                BUS_WAIT: begin
                    // A response in the final wait cycle wins over the timeout.
                    if (w_sel_rvalid) begin
                        r_rdata <= w_sel_rdata;
                        r_state <= BUS_RESP;
                    end else if (w_timeout) begin
                        r_state <= BUS_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BUS_RESP: r_state <= BUS_IDLE;
                BUS_ERR:  r_state <= BUS_IDLE;
                default:  r_state <= BUS_IDLE;
            endcase
        end
    end

    assign m_gnt_o    = (r_state == BUS_IDLE) && m_req_i;
    assign m_rvalid_o = (r_state == BUS_RESP) || (r_state == BUS_ERR);
    assign m_err_o    = (r_state == BUS_ERR);
    assign m_rdata_o  = (r_state == BUS_RESP) ? r_rdata : '0;

    assign s_req_o   = w_sreq;
    assign s_we_o    = r_we;
    assign s_addr_o  = r_addr;
    assign s_wdata_o = r_wdata;
    assign s_be_o    = r_be;

endmodule

// File: tb/tb_riscv_bus_ctrl.sv
// Scoreboard bench for riscv_bus_ctrl: expected responses are queued at grant
// time and matched against each m_rvalid_o pulse, including its cycle.
module tb_riscv_bus_ctrl;

    localparam int TO = 255;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        m_req_i, m_we_i;
    logic [31:0] m_addr_i, m_wdata_i;
    logic [3:0]  m_be_i;
    logic        m_gnt_o, m_rvalid_o, m_err_o;
    logic [31:0] m_rdata_o;
    logic [2:0]  s_req_o;
    logic        s_we_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_be_o;
    logic [2:0]  s_rvalid_i;
    logic [95:0] s_rdata_i;

    logic [2:0]  rv = 3'b000;
    logic [2:0]  noise_mask = 3'b000;
    logic [31:0] slv_data [3];
    int          slv_delay [3];
    int          pend [3];

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_gnt;
    int   g1, g2;

    riscv_bus_ctrl dut (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .m_req_i    (m_req_i),
        .m_we_i     (m_we_i),
        .m_addr_i   (m_addr_i),
        .m_wdata_i  (m_wdata_i),
        .m_be_i     (m_be_i),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .m_err_o    (m_err_o),
        .s_req_o    (s_req_o),
        .s_we_o     (s_we_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_be_o     (s_be_o),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    assign s_rvalid_i = rv | noise_mask;
    always_comb begin
        s_rdata_i = '0;
        for (int i = 0; i < 3; i++) s_rdata_i[i*32 +: 32] = slv_data[i];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Slave model: a slave answers slv_delay cycles after it sees its s_req (-1 = never).
    always @(negedge clk_i) begin
        for (int i = 0; i < 3; i++) begin
            if (!arstn_i)              pend[i] = -1;
            else if (s_req_o[i])       pend[i] = slv_delay[i];
            else if (pend[i] >= 0)     pend[i] = pend[i] - 1;
            rv[i] = (pend[i] == 0);
        end
    end

    always @(negedge clk_i) begin
        if (arstn_i && m_rvalid_o) begin
            if (q.size() == 0) begin
                check("unexpected_rvalid", 64'(m_rvalid_o), 64'd0);
            end else begin
                mon_e = q.pop_front();
                check("resp_err", 64'(m_err_o), 64'(mon_e.err));
                check("resp_rdata", 64'(m_rdata_o), 64'(mon_e.data));
                check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Returns at the negedge of the cycle after the grant (ISSUE or ERR).
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic hold, input int slv,
                        input logic exp_err, input logic [31:0] exp_data, input int lat);
        int   n;
        exp_t e;
        logic [2:0] one = 3'b001;
        m_req_i = 1'b1; m_we_i = we; m_addr_i = addr; m_wdata_i = wdata; m_be_i = be;
        #1;
        n = 0;
        while (!m_gnt_o && n < 400) begin
            @(negedge clk_i); #1; n++;
        end
        check("grant", 64'(m_gnt_o), 64'd1);
        last_gnt = cyc;
        e.err = exp_err; e.data = exp_data; e.cyc = cyc + lat;
        q.push_back(e);
        @(negedge clk_i);
        if (!hold) m_req_i = 1'b0;
        if (hold) check("gnt_busy", 64'(m_gnt_o), 64'd0);
        if (slv < 0) begin
            check("sreq_none", 64'(s_req_o), 64'd0);
        end else begin
            check("sreq", 64'(s_req_o), 64'(one << slv));
            check("s_we", 64'(s_we_o), 64'(we));
            check("s_addr", 64'(s_addr_o), 64'(addr));
            check("s_wdata", 64'(s_wdata_o), 64'(wdata));
            check("s_be", 64'(s_be_o), 64'(be));
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk_i); n++;
        end
        check("resp_arrived", 64'(q.size() == 0), 64'd1);
        q.delete();
        @(negedge clk_i);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn_i = 1'b0;
        m_req_i = 1'b0; m_we_i = 1'b0; m_addr_i = '0; m_wdata_i = '0; m_be_i = '0;
        slv_data[0] = 32'hDEADBEEF; slv_data[1] = 32'h0000_1234; slv_data[2] = 32'hCAFE_0002;
        for (int i = 0; i < 3; i++) begin
            slv_delay[i] = -1;
            pend[i] = -1;
        end

        repeat (3) @(negedge clk_i);
        #1;
        check("rst_rvalid", 64'(m_rvalid_o), 64'd0);
        check("rst_err", 64'(m_err_o), 64'd0);
        check("rst_rdata", 64'(m_rdata_o), 64'd0);
        check("rst_sreq", 64'(s_req_o), 64'd0);
        check("rst_swe", 64'(s_we_o), 64'd0);
        check("rst_saddr", 64'(s_addr_o), 64'd0);
        check("rst_swdata", 64'(s_wdata_o), 64'd0);
        check("rst_sbe", 64'(s_be_o), 64'd0);
        m_req_i = 1'b1; #1;
        check("rst_idle_gnt", 64'(m_gnt_o), 64'd1);
        m_req_i = 1'b0;
        @(negedge clk_i);
        arstn_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // RAM read, answer 2 cycles after s_req
        slv_delay[0] = 2;
        send(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 0, 1'b0, 32'hDEADBEEF, 4);
        wait_done(50);

        // GPIO write, acknowledged in the ISSUE cycle itself
        slv_delay[1] = 0;
        send(1'b1, 32'h1000_0000, 32'h0000_00A5, 4'b0001, 1'b0, 1, 1'b0, 32'h0000_1234, 2);
        wait_done(50);

        // decode errors
        send(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, -1, 1'b1, 32'h0, 1);
        wait_done(50);
        send(1'b1, 32'hF000_0004, 32'h1, 4'hF, 1'b0, -1, 1'b1, 32'h0, 1);
        wait_done(50);

        // UART silent: timeout after TO wait cycles
        slv_delay[2] = -1;
        send(1'b0, 32'h2000_0000, 32'h0, 4'hF, 1'b0, 2, 1'b1, 32'h0, TO + 2);
        wait_done(TO + 50);

        // response exactly in the last wait cycle beats the timeout
        slv_delay[2] = TO;
        send(1'b0, 32'h2000_0008, 32'h0, 4'hF, 1'b0, 2, 1'b0, 32'hCAFE_0002, TO + 2);
        wait_done(TO + 50);

        // one cycle too late: timeout, and the stray rvalid in ERR is ignored
        slv_delay[2] = TO + 1;
        send(1'b0, 32'h2000_000C, 32'h0, 4'hF, 1'b0, 2, 1'b1, 32'h0, TO + 2);
        wait_done(TO + 50);
        repeat (3) @(negedge clk_i);

        // GPIO rvalid alongside UART: only UART data is returned
        slv_delay[2] = 3;
        slv_data[1]  = 32'hBAD0_0001;
        noise_mask   = 3'b010;
        send(1'b0, 32'h2000_0010, 32'h0, 4'hF, 1'b0, 2, 1'b0, 32'hCAFE_0002, 5);
        wait_done(50);
        noise_mask = 3'b000;

        // rvalid activity while idle is ignored
        noise_mask = 3'b111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i); #1;
            check("idle_quiet", 64'(m_rvalid_o), 64'd0);
        end
        noise_mask = 3'b000;
        repeat (2) @(negedge clk_i);

        // request held: next grant only after the response cycle
        slv_delay[0] = 1;
        slv_data[0]  = 32'h1111_2222;
        send(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b1, 0, 1'b0, 32'h1111_2222, 3);
        g1 = last_gnt;
        send(1'b0, 32'h0000_0024, 32'h0, 4'hF, 1'b0, 0, 1'b0, 32'h1111_2222, 3);
        g2 = last_gnt;
        check("b2b_gap", 64'(g2 - g1), 64'd4);
        wait_done(50);

        // reset in WAIT aborts the transfer without a response
        slv_delay[2] = -1;
        send(1'b1, 32'h2000_0040, 32'h5555_AAAA, 4'hF, 1'b0, 2, 1'b1, 32'h0, TO + 2);
        repeat (3) @(negedge clk_i);
        arstn_i = 1'b0;
        #1;
        q.delete();
        check("abort_rvalid", 64'(m_rvalid_o), 64'd0);
        check("abort_sreq", 64'(s_req_o), 64'd0);
        check("abort_swe", 64'(s_we_o), 64'd0);
        check("abort_saddr", 64'(s_addr_o), 64'd0);
        check("abort_swdata", 64'(s_wdata_o), 64'd0);
        check("abort_sbe", 64'(s_be_o), 64'd0);
        m_req_i = 1'b1; #1;
        check("abort_idle_gnt", 64'(m_gnt_o), 64'd1);
        m_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        arstn_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i); #1;
            check("post_abort_quiet", 64'(m_rvalid_o), 64'd0);
        end

        slv_delay[0] = 2;
        slv_data[0]  = 32'h0BAD_F00D;
        send(1'b0, 32'h0000_0030, 32'h0, 4'hF, 1'b0, 0, 1'b0, 32'h0BAD_F00D, 4);
        wait_done(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
